pipe_mips32: RTL and testbench



---
 rtl/pipe_mips32.sv | 158 +++++++++++++++
 tb/tb_pipe_mips32.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset core (IF/ID/EX/MEM/WB), unified word memory, no interlocks.
// One instruction per cycle, 5-cycle fetch-to-writeback; taken branches squash two slots, HLT stalls fetch.
module pipe_mips32 (
  input  logic clk,
  input  logic rst,
  output logic halted
);
  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  logic [31:0] reg_bank [0:31];
  logic [31:0] mem [0:1023];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic [31:0] IF_ID_IR, IF_ID_NPC;
  logic [31:0] ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_IMM;
  logic [31:0] EX_MEM_IR, EX_MEM_ALU, EX_MEM_B;
  logic [31:0] MEM_WB_IR, MEM_WB_ALU, MEM_WB_LMD;

  logic [5:0]  wb_op, ex_op;
  logic        wb_en;
  logic [4:0]  wb_dst, id_rs, id_rt;
  logic [31:0] wb_val, id_a, id_b, id_imm, ex_alu;
  logic        branch_taken, hlt_pending;

  assign halted = HALTED;

  // Writeback selection; also feeds the same-cycle bypass into ID.
  always_comb begin
    wb_op  = MEM_WB_IR[31:26];
    wb_en  = 1'b0;
    wb_dst = MEM_WB_IR[15:11];
    wb_val = MEM_WB_ALU;
    if (wb_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL}) begin
      wb_en = 1'b1;
    end else if (wb_op inside {OP_ADDI, OP_SUBI, OP_SLTI}) begin
      wb_en  = 1'b1;
      wb_dst = MEM_WB_IR[20:16];
    end else if (wb_op == OP_LW) begin
      wb_en  = 1'b1;
      wb_dst = MEM_WB_IR[20:16];
      wb_val = MEM_WB_LMD;
    end
    if (wb_dst == 5'd0 || HALTED || rst) wb_en = 1'b0;
  end

  always_comb begin
    id_rs  = IF_ID_IR[25:21];
    id_rt  = IF_ID_IR[20:16];
    id_a   = reg_bank[id_rs];
    id_b   = reg_bank[id_rt];
    if (wb_en && wb_dst == id_rs) id_a = wb_val;
    if (wb_en && wb_dst == id_rt) id_b = wb_val;
    if (id_rs == 5'd0) id_a = 32'd0;
    if (id_rt == 5'd0) id_b = 32'd0;
    id_imm = {{16{IF_ID_IR[15]}}, IF_ID_IR[15:0]};
  end

  always_comb begin
    ex_op = ID_EX_IR[31:26];
    case (ex_op)
      OP_ADD:                 ex_alu = ID_EX_A + ID_EX_B;
      OP_SUB:                 ex_alu = ID_EX_A - ID_EX_B;
      OP_AND:                 ex_alu = ID_EX_A & ID_EX_B;
      OP_OR:                  ex_alu = ID_EX_A | ID_EX_B;
      OP_SLT:                 ex_alu = {31'd0, $signed(ID_EX_A) < $signed(ID_EX_B)};
      OP_MUL:                 ex_alu = ID_EX_A * ID_EX_B;
      OP_ADDI, OP_LW, OP_SW:  ex_alu = ID_EX_A + ID_EX_IMM;
      OP_SUBI:                ex_alu = ID_EX_A - ID_EX_IMM;
      OP_SLTI:                ex_alu = {31'd0, $signed(ID_EX_A) < $signed(ID_EX_IMM)};
      OP_BNEQZ, OP_BEQZ:      ex_alu = ID_EX_NPC + ID_EX_IMM;
      default:                ex_alu = 32'd0;
    endcase
    branch_taken = (ex_op == OP_BEQZ  && ID_EX_A == 32'd0) ||
                   (ex_op == OP_BNEQZ && ID_EX_A != 32'd0);
    hlt_pending  = (IF_ID_IR[31:26] == OP_HLT) || (ID_EX_IR[31:26] == OP_HLT) ||
                   (EX_MEM_IR[31:26] == OP_HLT) || (MEM_WB_IR[31:26] == OP_HLT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      IF_ID_IR     <= 32'd0;
      IF_ID_NPC    <= 32'd0;
      ID_EX_IR     <= 32'd0;
      ID_EX_NPC    <= 32'd0;
      ID_EX_A      <= 32'd0;
      ID_EX_B      <= 32'd0;
      ID_EX_IMM    <= 32'd0;
      EX_MEM_IR    <= 32'd0;
      EX_MEM_ALU   <= 32'd0;
      EX_MEM_B     <= 32'd0;
      MEM_WB_IR    <= 32'd0;
      MEM_WB_ALU   <= 32'd0;
      MEM_WB_LMD   <= 32'd0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= branch_taken;
      // A taken branch wins over the halt stall so a squashed HLT never stalls fetch.
      if (branch_taken) begin
        PC        <= ex_alu;
        IF_ID_IR  <= 32'd0;
        IF_ID_NPC <= 32'd0;
      end else if (hlt_pending) begin
        IF_ID_IR  <= 32'd0;
      end else begin
        IF_ID_IR  <= mem[PC[9:0]];
        IF_ID_NPC <= PC + 32'd1;
        PC        <= PC + 32'd1;
      end
      if (branch_taken) begin
        ID_EX_IR  <= 32'd0;
        ID_EX_NPC <= 32'd0;
        ID_EX_A   <= 32'd0;
        ID_EX_B   <= 32'd0;
        ID_EX_IMM <= 32'd0;
      end else begin
        ID_EX_IR  <= IF_ID_IR;
        ID_EX_NPC <= IF_ID_NPC;
        ID_EX_A   <= id_a;
        ID_EX_B   <= id_b;
        ID_EX_IMM <= id_imm;
      end
      EX_MEM_IR  <= ID_EX_IR;
      EX_MEM_ALU <= ex_alu;
      EX_MEM_B   <= ID_EX_B;
      MEM_WB_IR  <= EX_MEM_IR;
      MEM_WB_ALU <= EX_MEM_ALU;
      MEM_WB_LMD <= mem[EX_MEM_ALU[9:0]];
      if (MEM_WB_IR[31:26] == OP_HLT) HALTED <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !HALTED && EX_MEM_IR[31:26] == OP_SW) mem[EX_MEM_ALU[9:0]] <= EX_MEM_B;
  end

  always_ff @(posedge clk) begin
    if (wb_en) reg_bank[wb_dst] <= wb_val;
  end

  logic unused_bits;
  assign unused_bits = ^{EX_MEM_IR[25:0], MEM_WB_IR[25:21], MEM_WB_IR[10:0]};
endmodule

// File: tb/tb_pipe_mips32.sv
// Directed and randomized programs for pipe_mips32, checked against a sequential ISA-level model.
module tb_pipe_mips32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] img_mem [0:1023];
  logic [31:0] img_rf  [0:31];
  logic [31:0] m_dm    [0:1023];
  logic [31:0] m_rf    [0:31];
  int run_cycles, run_pulses, exp_fetched, exp_taken;

  localparam logic [31:0] HLT = 32'hfc000000;
  localparam logic [31:0] NOP = 32'h00000000;

  pipe_mips32 dut (.clk(clk), .rst(rst), .halted(halted));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int op, input int rd, input int rs, input int rt);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setup();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      img_mem[i] = 32'd0;
      dut.mem[i] = 32'd0;
    end
    for (int r = 0; r < 32; r++) begin
      img_rf[r] = r;
      dut.reg_bank[r] = r;
    end
  endtask

  task automatic put_mem(input int a, input logic [31:0] v);
    img_mem[a] = v;
    dut.mem[a] = v;
  endtask

  task automatic put_reg(input int r, input logic [31:0] v);
    img_rf[r] = v;
    dut.reg_bank[r] = v;
  endtask

  // Architectural semantics, one instruction at a time; pipeline effects appear only as fetch slots.
  task automatic model_exec();
    logic [31:0] pc, ir, a, b, imm, addr;
    logic [5:0]  op;
    pc = 32'd0;
    exp_fetched = 0;
    exp_taken = 0;
    for (int i = 0; i < 1024; i++) m_dm[i] = img_mem[i];
    for (int r = 0; r < 32; r++) m_rf[r] = img_rf[r];
    for (int step = 0; step < 2000; step++) begin
      ir  = m_dm[pc[9:0]];
      exp_fetched++;
      op  = ir[31:26];
      a   = (ir[25:21] == 5'd0) ? 32'd0 : m_rf[ir[25:21]];
      b   = (ir[20:16] == 5'd0) ? 32'd0 : m_rf[ir[20:16]];
      imm = {{16{ir[15]}}, ir[15:0]};
      addr = a + imm;
      pc  = pc + 32'd1;
      if (op == 6'd63) break;
      case (op)
        6'd0:  if (ir[15:11] != 0) m_rf[ir[15:11]] = a + b;
        6'd1:  if (ir[15:11] != 0) m_rf[ir[15:11]] = a - b;
        6'd2:  if (ir[15:11] != 0) m_rf[ir[15:11]] = a & b;
        6'd3:  if (ir[15:11] != 0) m_rf[ir[15:11]] = a | b;
        6'd4:  if (ir[15:11] != 0) m_rf[ir[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'd5:  if (ir[15:11] != 0) m_rf[ir[15:11]] = a * b;
        6'd10: if (ir[20:16] != 0) m_rf[ir[20:16]] = a + imm;
        6'd11: if (ir[20:16] != 0) m_rf[ir[20:16]] = a - imm;
        6'd12: if (ir[20:16] != 0) m_rf[ir[20:16]] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        6'd8:  if (ir[20:16] != 0) m_rf[ir[20:16]] = m_dm[addr[9:0]];
        6'd9:  m_dm[addr[9:0]] = b;
        6'd13: if (a != 0) begin pc = pc + imm; exp_taken++; exp_fetched += 2; end
        6'd14: if (a == 0) begin pc = pc + imm; exp_taken++; exp_fetched += 2; end
        default: ;
      endcase
    end
  endtask

  task automatic go(input string tag);
    model_exec();
    @(negedge clk);
    rst = 1'b0;
    run_cycles = 0;
    run_pulses = 0;
    while (halted !== 1'b1 && run_cycles < 600) begin
      @(posedge clk);
      #1;
      run_cycles++;
      if (dut.TAKEN_BRANCH === 1'b1) run_pulses++;
    end
    check({tag, " halted"}, {31'd0, halted}, 32'd1);
    check({tag, " halt_edge"}, run_cycles, exp_fetched + 4);
    check({tag, " branch_pulses"}, run_pulses, exp_taken);
  endtask

  task automatic compare_state(input string tag, input int lo, input int hi);
    for (int r = 0; r < 32; r++) check($sformatf("%s R%0d", tag, r), dut.reg_bank[r], m_rf[r]);
    for (int i = lo; i <= hi; i++) check($sformatf("%s mem[%0d]", tag, i), dut.mem[i], m_dm[i]);
  endtask

  task automatic load_las();
    put_mem(120, 32'd85);
    put_mem(121, 32'h0000dead);
    put_mem(0, 32'h28010078);
    put_mem(1, 32'h0c631800);
    put_mem(2, 32'h0c631800);
    put_mem(3, 32'h20220000);
    put_mem(4, 32'h0c631800);
    put_mem(5, 32'h0c631800);
    put_mem(6, 32'h2842002d);
    put_mem(7, 32'h0c631800);
    put_mem(8, 32'h0c631800);
    put_mem(9, 32'h24220001);
    put_mem(10, HLT);
  endtask

  task automatic gen_random(input int n);
    int op_tab [14];
    op_tab = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 8, 9, 13, 14, 20};
    for (int r = 1; r < 31; r++) put_reg(r, $urandom);
    put_reg(0, 32'd0);
    put_reg(31, 32'd600);
    for (int i = 600; i < 856; i++) put_mem(i, $urandom);
    for (int i = 0; i < n; i++) begin
      int op, d, s, t, j;
      logic [31:0] w;
      op = op_tab[$urandom_range(13, 0)];
      d  = $urandom_range(30, 0);
      s  = $urandom_range(31, 0);
      t  = $urandom_range(31, 0);
      case (op)
        0, 1, 2, 3, 4, 5: w = enc_r(op, d, s, t);
        10, 11, 12:       w = enc_i(op, d, s, int'($urandom));
        8:                w = enc_i(8, d, 31, $urandom_range(255, 0));
        9:                w = enc_i(9, t, 31, $urandom_range(255, 0));
        13, 14: begin
          j = $urandom_range(n, i + 1);
          w = enc_i(op, 0, $urandom_range(30, 0), 3 * j - 3 * i - 1);
        end
        default: begin
          w = $urandom;
          w[31:26] = 6'd20;
        end
      endcase
      put_mem(3 * i, w);
    end
    put_mem(3 * n, HLT);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset PC", dut.PC, 32'd0);
    check("reset HALTED", {31'd0, dut.HALTED}, 32'd0);
    check("reset halted port", {31'd0, halted}, 32'd0);
    check("reset TAKEN_BRANCH", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    check("reset IF_ID_IR", dut.IF_ID_IR, NOP);
    check("reset ID_EX_IR", dut.ID_EX_IR, NOP);
    check("reset EX_MEM_IR", dut.EX_MEM_IR, NOP);
    check("reset MEM_WB_IR", dut.MEM_WB_IR, NOP);

    // Load / add / store, then verify halt is sticky and PC frozen just past HLT.
    setup();
    load_las();
    go("las");
    check("las mem[121]", dut.mem[121], 32'd130);
    check("las R2", dut.reg_bank[2], 32'd130);
    compare_state("las", 118, 124);
    repeat (15) @(posedge clk);
    #1;
    check("las halted sticky", {31'd0, halted}, 32'd1);
    check("las PC frozen", dut.PC, 32'd11);

    // ALU coverage with reg_bank[k] = k.
    setup();
    put_mem(0, enc_r(0, 10, 1, 2));
    put_mem(1, enc_r(1, 11, 7, 2));
    put_mem(2, enc_r(2, 12, 6, 3));
    put_mem(3, enc_r(3, 13, 4, 1));
    put_mem(4, enc_r(4, 14, 2, 1));
    put_mem(5, enc_r(5, 15, 3, 4));
    put_mem(6, enc_i(11, 16, 0, 1));
    put_mem(7, HLT);
    go("alu");
    check("alu ADD", dut.reg_bank[10], 32'd3);
    check("alu SUB", dut.reg_bank[11], 32'd5);
    check("alu AND", dut.reg_bank[12], 32'd2);
    check("alu OR", dut.reg_bank[13], 32'd5);
    check("alu SLT", dut.reg_bank[14], 32'd0);
    check("alu MUL", dut.reg_bank[15], 32'd12);
    check("alu SUBI", dut.reg_bank[16], 32'hffffffff);
    compare_state("alu", 0, 7);

    // R0 is never written.
    setup();
    put_mem(0, enc_i(10, 0, 0, 7));
    put_mem(3, enc_i(10, 5, 0, 1));
    put_mem(4, HLT);
    go("r0");
    check("r0 R0", dut.reg_bank[0], 32'd0);
    check("r0 R5", dut.reg_bank[5], 32'd1);

    // Branch squash, taken then not taken.
    for (int pass = 0; pass < 2; pass++) begin
      setup();
      put_reg(1, pass);
      put_reg(5, 32'h55);
      put_reg(6, 32'h55);
      put_reg(7, 32'h55);
      put_mem(0, enc_i(14, 0, 1, 2));
      put_mem(1, enc_i(10, 5, 0, 9));
      put_mem(2, enc_i(10, 6, 0, 9));
      put_mem(3, enc_i(10, 7, 0, 9));
      put_mem(4, HLT);
      go($sformatf("br%0d", pass));
      check($sformatf("br%0d R5", pass), dut.reg_bank[5], (pass == 0) ? 32'h55 : 32'd9);
      check($sformatf("br%0d R6", pass), dut.reg_bank[6], (pass == 0) ? 32'h55 : 32'd9);
      check($sformatf("br%0d R7", pass), dut.reg_bank[7], 32'd9);
      check($sformatf("br%0d pulses", pass), run_pulses, (pass == 0) ? 32'd1 : 32'd0);
    end

    // Nothing after HLT may change state.
    setup();
    put_reg(8, 32'h1234);
    put_mem(700, 32'hdeadbeef);
    put_mem(0, HLT);
    put_mem(1, enc_i(10, 8, 0, 1));
    put_mem(2, enc_i(9, 8, 0, 700));
    go("frz");
    repeat (20) @(posedge clk);
    #1;
    check("frz halted", {31'd0, halted}, 32'd1);
    check("frz PC", dut.PC, 32'd1);
    check("frz R8", dut.reg_bank[8], 32'h1234);
    check("frz mem[700]", dut.mem[700], 32'hdeadbeef);

    // Reset on the edge where the SW would write: store is dropped, program reruns from 0.
    setup();
    load_las();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid no spurious store", dut.mem[121], 32'h0000dead);
    check("mid PC", dut.PC, 32'd0);
    check("mid EX_MEM_IR", dut.EX_MEM_IR, NOP);
    check("mid MEM_WB_IR", dut.MEM_WB_IR, NOP);
    go("mid");
    check("mid mem[121]", dut.mem[121], 32'd130);
    compare_state("mid", 118, 124);

    // Randomized programs with two NOPs after each instruction to respect the scheduling rule.
    for (int k = 0; k < 4; k++) begin
      setup();
      gen_random(30);
      go($sformatf("rnd%0d", k));
      compare_state($sformatf("rnd%0d", k), 600, 855);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
